// File: rtl/vm_pkg.sv
// Shared encodings, money width and coin values for the vending-machine
// transaction controller.
package vm_pkg;

   localparam int              MONEY_W   = 12;
   localparam logic [MONEY_W-1:0] MONEY_MAX = 12'd4095;

   localparam logic [7:0] NICKEL_C  = 8'd5;
   localparam logic [7:0] DIME_C    = 8'd10;
   localparam logic [7:0] QUARTER_C = 8'd25;
   localparam logic [7:0] HALF_C    = 8'd50;
   localparam logic [7:0] DOLLAR_C  = 8'd100;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PAY      = 3'd1,
      S_DISPENSE = 3'd2,
      S_CHANGE   = 3'd3,
      S_REFUND   = 3'd4
   } vm_state_e;

   typedef struct packed {
      logic nickel;
      logic dime;
      logic quarter;
      logic half_dollar;
      logic dollar;
   } coins_t;

   // Credit never wraps: a full machine keeps reporting the ceiling value.
   function automatic logic [MONEY_W-1:0] sat_add(input logic [MONEY_W-1:0] a,
                                                  input logic [7:0]         b);
      logic [MONEY_W:0] sum;
      sum = {1'b0, a} + (MONEY_W+1)'(b);
      return (sum > {1'b0, MONEY_MAX}) ? MONEY_MAX : sum[MONEY_W-1:0];
   endfunction

endpackage

// File: rtl/vm_coin_accumulator.sv
// Adds every coin asserted this cycle to the running credit, with saturation.
module vm_coin_accumulator
   import vm_pkg::*;
(
   input  logic [MONEY_W-1:0] total_in,
   input  coins_t             coins,
   output logic [MONEY_W-1:0] total_out,
   output logic               any_coin
);

   logic [7:0] coin_sum;

   // Worst case all five coins together is 190, so eight bits never overflow.
   always_comb begin
      coin_sum = (coins.nickel      ? NICKEL_C  : 8'd0)
               + (coins.dime        ? DIME_C    : 8'd0)
               + (coins.quarter     ? QUARTER_C : 8'd0)
               + (coins.half_dollar ? HALF_C    : 8'd0)
               + (coins.dollar      ? DOLLAR_C  : 8'd0);
   end

   assign any_coin  = |coins;
   assign total_out = sat_add(total_in, coin_sum);

endmodule

// File: rtl/vm_transaction_ctrl.sv
// Vending-machine transaction FSM: selection, payment with inactivity timeout,
// dispense, and change/refund handshakes.
module vm_transaction_ctrl
   import vm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               item_selection_valid,
   input  logic [MONEY_W-1:0] item_price,
   input  logic               nickel,
   input  logic               dime,
   input  logic               quarter,
   input  logic               half_dollar,
   input  logic               dollar,
   input  logic               cancel,
   input  logic               dispense_done,
   input  logic               change_done,
   output logic               selection_en,
   output logic               payment_en,
   output logic               dispense_start,
   output logic               change_start,
   output logic [MONEY_W-1:0] change_amount,
   output logic [MONEY_W-1:0] total_money,
   output logic               coin_reject,
   output logic [2:0]         state
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   vm_state_e          state_q, state_d;
   logic [MONEY_W-1:0] price_q, price_d;
   logic [MONEY_W-1:0] total_q, total_d;
   logic [MONEY_W-1:0] change_amount_q, change_amount_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dispense_start_q, dispense_start_d;
   logic               change_start_q, change_start_d;
   logic               coin_reject_q, coin_reject_d;
   logic [MONEY_W-1:0] acc_total;
   logic               any_coin;
   logic               go_refund;

   vm_coin_accumulator u_acc (
      .total_in  (total_q),
      .coins     ('{nickel: nickel, dime: dime, quarter: quarter,
                    half_dollar: half_dollar, dollar: dollar}),
      .total_out (acc_total),
      .any_coin  (any_coin)
   );

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d          = state_q;
      price_d          = price_q;
      total_d          = total_q;
      change_amount_d  = change_amount_q;
      cnt_d            = '0;
      dispense_start_d = 1'b0;
      change_start_d   = 1'b0;
      coin_reject_d    = any_coin && (state_q != S_PAY);
      go_refund        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (item_selection_valid && (item_price != '0)) begin
               price_d = item_price;
               state_d = S_PAY;
            end
         end
         S_PAY: begin
            // Exit decisions use registered credit; this cycle's coins still count.
            total_d = acc_total;
            cnt_d   = any_coin ? '0 : cnt_q + CNT_W'(1);
            if (cancel) begin
               go_refund = 1'b1;
            end else if (total_q >= price_q) begin
               state_d          = S_DISPENSE;
               dispense_start_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               go_refund = 1'b1;
            end
            if (go_refund) begin
               state_d         = S_REFUND;
               change_amount_d = acc_total;
               change_start_d  = (acc_total != '0);
            end
         end
         S_DISPENSE: begin
            if (dispense_done) begin
               change_amount_d = total_q - price_q;
               if (total_q == price_q) begin
                  state_d = S_IDLE;
                  total_d = '0;
                  price_d = '0;
               end else begin
                  state_d        = S_CHANGE;
                  change_start_d = 1'b1;
               end
            end
         end
         S_CHANGE, S_REFUND: begin
            // An empty refund has nothing to hand back, so it skips the handshake.
            if (change_done || ((state_q == S_REFUND) && (change_amount_q == '0))) begin
               state_d = S_IDLE;
               total_d = '0;
               price_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= S_IDLE;
         price_q          <= '0;
         total_q          <= '0;
         change_amount_q  <= '0;
         cnt_q            <= '0;
         dispense_start_q <= 1'b0;
         change_start_q   <= 1'b0;
         coin_reject_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q          <= state_d;
         price_q          <= price_d;
         total_q          <= total_d;
         change_amount_q  <= change_amount_d;
         cnt_q            <= cnt_d;
         dispense_start_q <= dispense_start_d;
         change_start_q   <= change_start_d;
         coin_reject_q    <= coin_reject_d;
      end
   end

   assign selection_en   = (state_q == S_IDLE);
   assign payment_en     = (state_q == S_PAY);
   assign dispense_start = dispense_start_q;
   assign change_start   = change_start_q;
   assign change_amount  = change_amount_q;
   assign total_money    = total_q;
   assign coin_reject    = coin_reject_q;
   assign state          = state_q;

endmodule
